// File: rtl/acm_scrub_pkg.sv
// rtl/acm_scrub_pkg.sv - shared types and SECDED(39,32) helpers for the correction module
package acm_scrub_pkg;

    typedef enum logic [1:0] {
        ACM_IDLE    = 2'd0,
        ACM_CHECK   = 2'd1,
        ACM_CORRECT = 2'd2
    } acm_state_t;

    typedef enum logic [1:0] {
        SYN_OK = 2'd0,
        SYN_CE = 2'd1,
        SYN_UE = 2'd2
    } syn_class_t;

    typedef logic [15:0] ce_cnt_t;

    localparam logic [1:0] MODE_OFF    = 2'b00;
    localparam logic [1:0] MODE_SCRUB  = 2'b10;
    localparam logic [1:0] MODE_FORCED = 2'b11;

    // Hamming position (1..38, powers of two reserved for check bits) of data bit j
    function automatic logic [5:0] data_pos(input int j);
        int         cnt;
        logic [5:0] pos;
        cnt = 0;
        pos = '0;
        for (int p = 1; p < 39; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (cnt == j) pos = 6'(p);
                cnt++;
            end
        end
        return pos;
    endfunction

    function automatic logic [6:0] secded_encode(input logic [31:0] d);
        logic [6:0] c;
        logic [5:0] pos;
        c = '0;
        for (int j = 0; j < 32; j++) begin
            pos = data_pos(j);
            for (int i = 0; i < 6; i++) begin
                if (pos[i]) c[i] ^= d[j];
            end
        end
        c[6] = (^d) ^ (^c[5:0]);
        return c;
    endfunction

    // Odd overall parity marks a single flip; a position past 38 cannot be one
    function automatic syn_class_t secded_analyze(input logic [6:0] syn);
        if (syn == '0)                      return SYN_OK;
        else if ((^syn) && syn[5:0] <= 6'd38) return SYN_CE;
        else                                return SYN_UE;
    endfunction

    function automatic logic [31:0] secded_decode(input logic [31:0] d, input logic [6:0] syn);
        logic [31:0] r;
        r = d;
        for (int j = 0; j < 32; j++) begin
            if (data_pos(j) == syn[5:0]) r[j] = ~d[j];
        end
        return r;
    endfunction

endpackage

// File: rtl/acm_req_arb.sv
// rtl/acm_req_arb.sv - fixed-priority repair request filter, lowest eligible port wins
module acm_req_arb
    import acm_scrub_pkg::*;
#(
    parameter int RP = 2,
    parameter int AW = 5
) (
    input  logic [1:0]    mode_i,
    input  logic          wb_we_i,
    input  logic [AW-1:0] wb_add_i,
    input  logic [AW-1:0] r_add_i [RP],
    input  logic [31:0]   r_val_i [RP],
    input  logic          r_req_i [RP],
    output logic          valid_o,
    output logic [AW-1:0] add_o,
    output logic [31:0]   val_o
);

    logic [RP-1:0] elig;
    logic [RP-1:0] sel;

    always_comb begin
        elig = '0;
        for (int k = 0; k < RP; k++) begin
            elig[k] = (r_req_i[k] || mode_i == MODE_FORCED) && (r_add_i[k] != '0)
                      && !(wb_we_i && wb_add_i == r_add_i[k]);
        end
        sel     = elig & (~elig + RP'(1));
        valid_o = |elig;
        add_o   = '0;
        val_o   = '0;
        for (int k = 0; k < RP; k++) begin
            add_o |= {AW{sel[k]}} & r_add_i[k];
            val_o |= {32{sel[k]}} & r_val_i[k];
        end
    end

endmodule

// File: rtl/acm_scrub.sv
// rtl/acm_scrub.sv - SECDED repair engine with background scrubber beside the register file write port
module acm_scrub
    import acm_scrub_pkg::*;
#(
    parameter int N            = 32,
    parameter int RP           = 2,
    parameter int SCRUB_PERIOD = 1024,
    parameter int AW           = $clog2(N)
) (
    input  logic          s_clk_i,
    input  logic          s_resetn_i,
    input  logic [1:0]    s_mode_i,
    input  logic          s_wb_we_i,
    input  logic [AW-1:0] s_wb_add_i,
    input  logic [31:0]   s_wb_val_i,
    input  logic [AW-1:0] s_r_add_i [RP],
    input  logic [31:0]   s_r_val_i [RP],
    input  logic          s_r_req_i [RP],
    output logic [AW-1:0] s_scr_add_o,
    input  logic [31:0]   s_scr_val_i,
    output logic          s_we_o,
    output logic [AW-1:0] s_add_o,
    output logic [31:0]   s_val_o,
    output logic          s_busy_o,
    output logic          s_ue_o,
    output logic [15:0]   s_ce_cnt_o
);

    localparam int            TW         = $clog2(SCRUB_PERIOD);
    localparam logic [TW-1:0] TMR_RELOAD = TW'(SCRUB_PERIOD - 1);
    localparam logic [AW-1:0] ADD_LAST   = AW'(N - 1);

    acm_state_t    state_q, state_d;
    logic [AW-1:0] add_q, add_d;
    logic [31:0]   val_q, val_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          pend_q, pend_d;
    ce_cnt_t       ce_q, ce_d;
    logic [6:0]    chk_q [N];
    logic [6:0]    chk_d [N];

    logic          arb_valid;
    logic [AW-1:0] arb_add;
    logic [31:0]   arb_val;
    logic          mode_on, acm_we, ue, scr_launch;
    logic [6:0]    syn;
    syn_class_t    syn_cls;

    acm_req_arb #(.RP(RP), .AW(AW)) u_arb (
        .mode_i   (s_mode_i),
        .wb_we_i  (s_wb_we_i),
        .wb_add_i (s_wb_add_i),
        .r_add_i  (s_r_add_i),
        .r_val_i  (s_r_val_i),
        .r_req_i  (s_r_req_i),
        .valid_o  (arb_valid),
        .add_o    (arb_add),
        .val_o    (arb_val)
    );

    assign mode_on     = (s_mode_i != MODE_OFF);
    assign syn         = secded_encode(val_q) ^ chk_q[add_q];
    assign syn_cls     = secded_analyze(syn);
    assign s_scr_add_o = ptr_q;
    assign s_busy_o    = (state_q != ACM_IDLE);
    assign s_ue_o      = ue;
    assign s_ce_cnt_o  = ce_q;

    always_comb begin
        state_d    = state_q;
        add_d      = add_q;
        val_d      = val_q;
        ptr_d      = ptr_q;
        ce_d       = ce_q;
        acm_we     = 1'b0;
        ue         = 1'b0;
        scr_launch = 1'b0;
        if (!mode_on) begin
            state_d = ACM_IDLE;
        end else begin
            case (state_q)
                ACM_IDLE: begin
                    if (arb_valid) begin
                        add_d   = arb_add;
                        val_d   = arb_val;
                        state_d = ACM_CHECK;
                    end else if (pend_q && s_mode_i == MODE_SCRUB) begin
                        add_d      = ptr_q;
                        val_d      = s_scr_val_i;
                        scr_launch = 1'b1;
                        ptr_d      = (ptr_q == ADD_LAST) ? AW'(1) : ptr_q + AW'(1);
                        state_d    = ACM_CHECK;
                    end
                end
                ACM_CHECK: begin
                    if (s_wb_we_i && s_wb_add_i == add_q) begin
                        state_d = ACM_IDLE;
                    end else begin
                        case (syn_cls)
                            SYN_OK: state_d = ACM_IDLE;
                            SYN_CE: begin
                                val_d   = secded_decode(val_q, syn);
                                state_d = ACM_CORRECT;
                            end
                            default: begin
                                ue      = 1'b1;
                                state_d = ACM_IDLE;
                            end
                        endcase
                    end
                end
                ACM_CORRECT: begin
                    // A writeback to another register only delays us; one to ours makes the repair stale
                    if (s_wb_we_i) begin
                        if (s_wb_add_i == add_q) state_d = ACM_IDLE;
                    end else begin
                        acm_we  = 1'b1;
                        ce_d    = (ce_q == 16'hFFFF) ? ce_q : ce_q + 16'd1;
                        state_d = ACM_IDLE;
                    end
                end
                default: state_d = ACM_IDLE;
            endcase
        end
    end

    always_comb begin
        tmr_d  = tmr_q;
        pend_d = pend_q;
        if (s_mode_i != MODE_SCRUB) begin
            pend_d = 1'b0;
        end else begin
            if (scr_launch) pend_d = 1'b0;
            if (tmr_q == '0) begin
                pend_d = 1'b1;
                tmr_d  = TMR_RELOAD;
            end else begin
                tmr_d = tmr_q - TW'(1);
            end
        end
    end

    always_comb begin
        s_we_o  = s_wb_we_i | acm_we;
        s_add_o = s_wb_we_i ? s_wb_add_i : add_q;
        s_val_o = s_wb_we_i ? s_wb_val_i : val_q;
    end

    always_comb begin
        chk_d = chk_q;
        if (s_we_o && mode_on) chk_d[s_add_o] = secded_encode(s_val_o);
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q <= ACM_IDLE;
            add_q   <= '0;
            val_q   <= '0;
            ptr_q   <= AW'(1);
            tmr_q   <= TMR_RELOAD;
            pend_q  <= 1'b0;
            ce_q    <= '0;
            chk_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            add_q   <= add_d;
            val_q   <= val_d;
            ptr_q   <= ptr_d;
            tmr_q   <= tmr_d;
            pend_q  <= pend_d;
            ce_q    <= ce_d;
            chk_q   <= chk_d;
        end
    end

endmodule

// File: tb/tb_acm_scrub.sv
// tb/tb_acm_scrub.sv - directed vector bench for acm_scrub (N=32 main instance, N=8 scrub instance)
module tb_acm_scrub;

    logic        clk, rst_n;

    logic [1:0]  mode;
    logic        wb_we;
    logic [4:0]  wb_add;
    logic [31:0] wb_val;
    logic [4:0]  r_add [2];
    logic [31:0] r_val [2];
    logic        r_req [2];
    logic [4:0]  scr_add;
    logic [31:0] scr_val;
    logic        we, busy, ue;
    logic [4:0]  add;
    logic [31:0] val;
    logic [15:0] ce;
    logic [31:0] rf [32];

    logic [1:0]  sm;
    logic        swe;
    logic [2:0]  sa;
    logic [31:0] sv;
    logic [2:0]  sr_add [2];
    logic [31:0] sr_val [2];
    logic        sr_req [2];
    logic [2:0]  scr_add_s;
    logic [31:0] scr_val_s;
    logic        we_s, busy_s, ue_s;
    logic [2:0]  add_s;
    logic [31:0] val_s;
    logic [15:0] ce_s;
    logic [31:0] rf_s [8];
    logic        corrupt;

    int n_vec = 0;
    int n_err = 0;

    acm_scrub dut (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_mode_i(mode),
        .s_wb_we_i(wb_we), .s_wb_add_i(wb_add), .s_wb_val_i(wb_val),
        .s_r_add_i(r_add), .s_r_val_i(r_val), .s_r_req_i(r_req),
        .s_scr_add_o(scr_add), .s_scr_val_i(scr_val),
        .s_we_o(we), .s_add_o(add), .s_val_o(val),
        .s_busy_o(busy), .s_ue_o(ue), .s_ce_cnt_o(ce)
    );

    acm_scrub #(.N(8), .RP(2), .SCRUB_PERIOD(4)) dut_s (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_mode_i(sm),
        .s_wb_we_i(swe), .s_wb_add_i(sa), .s_wb_val_i(sv),
        .s_r_add_i(sr_add), .s_r_val_i(sr_val), .s_r_req_i(sr_req),
        .s_scr_add_o(scr_add_s), .s_scr_val_i(scr_val_s),
        .s_we_o(we_s), .s_add_o(add_s), .s_val_o(val_s),
        .s_busy_o(busy_s), .s_ue_o(ue_s), .s_ce_cnt_o(ce_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign scr_val   = rf[scr_add];
    assign scr_val_s = rf_s[scr_add_s];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we) begin
            rf[add] <= val;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf_s[i] <= '0;
        end else if (corrupt) begin
            rf_s[3] <= rf_s[3] ^ 32'h0000_0200;
        end else if (we_s) begin
            rf_s[add_s] <= val_s;
        end
    end

    typedef struct packed {
        logic [1:0]  md;
        logic        wwe;
        logic [4:0]  wa;
        logic [31:0] wv;
        logic [4:0]  a0;
        logic [4:0]  a1;
        logic [1:0]  rq;
        logic [31:0] f0;
        logic [31:0] f1;
        logic        ewe;
        logic [4:0]  eadd;
        logic [31:0] ev;
        logic        eue;
        logic        ebusy;
        logic [15:0] ece;
    } vec_t;

    localparam int NV = 43;
    vec_t tv [NV];

    function automatic vec_t mk(input int md, input int wwe, input int wa, input logic [31:0] wv,
                                input int a0, input int a1, input int rq,
                                input logic [31:0] f0, input logic [31:0] f1,
                                input int ewe, input int eadd, input logic [31:0] ev,
                                input int eue, input int ebusy, input int ece);
        vec_t v;
        v.md = 2'(md);   v.wwe = 1'(wwe); v.wa = 5'(wa); v.wv = wv;
        v.a0 = 5'(a0);   v.a1 = 5'(a1);   v.rq = 2'(rq); v.f0 = f0; v.f1 = f1;
        v.ewe = 1'(ewe); v.eadd = 5'(eadd); v.ev = ev;
        v.eue = 1'(eue); v.ebusy = 1'(ebusy); v.ece = 16'(ece);
        return v;
    endfunction

    function automatic vec_t idle(input int md, input int ewe, input int eadd, input logic [31:0] ev,
                                  input int eue, input int ebusy, input int ece);
        return mk(md, 0, 0, 0, 0, 0, 0, 0, 0, ewe, eadd, ev, eue, ebusy, ece);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  exp_seq [7];
        logic [2:0]  last;
        int          ntr;
        logic        rep;
        logic [31:0] rep_val;

        tv[0]  = mk(1, 1, 5, 32'h0000_00FF, 0, 0, 0, 0, 0, 1, 5, 32'h0000_00FF, 0, 0, 0);
        tv[1]  = mk(1, 1, 7, 32'hA5A5_0F0F, 0, 0, 0, 0, 0, 1, 7, 32'hA5A5_0F0F, 0, 0, 0);
        tv[2]  = mk(1, 1, 6, 32'h1111_2222, 0, 0, 0, 0, 0, 1, 6, 32'h1111_2222, 0, 0, 0);
        tv[3]  = mk(1, 1, 4, 32'h0000_4444, 0, 0, 0, 0, 0, 1, 4, 32'h0000_4444, 0, 0, 0);
        tv[4]  = mk(1, 1, 9, 32'h0000_0009, 0, 0, 0, 0, 0, 1, 9, 32'h0000_0009, 0, 0, 0);
        tv[5]  = mk(1, 0, 0, 0, 5, 0, 1, 32'h8, 0, 0, 0, 0, 0, 0, 0);
        tv[6]  = idle(1, 0, 0, 0, 0, 1, 0);
        tv[7]  = idle(1, 1, 5, 32'h0000_00FF, 0, 1, 0);
        tv[8]  = idle(1, 0, 0, 0, 0, 0, 1);
        tv[9]  = mk(1, 0, 0, 0, 7, 0, 1, 32'h3, 0, 0, 0, 0, 0, 0, 1);
        tv[10] = idle(1, 0, 0, 0, 1, 1, 1);
        tv[11] = idle(1, 0, 0, 0, 0, 0, 1);
        tv[12] = idle(1, 0, 0, 0, 0, 0, 1);
        tv[13] = mk(1, 0, 0, 0, 6, 0, 1, 32'h0001_0000, 0, 0, 0, 0, 0, 0, 1);
        tv[14] = idle(1, 0, 0, 0, 0, 1, 1);
        tv[15] = mk(1, 1, 9, 32'h0000_0999, 0, 0, 0, 0, 0, 1, 9, 32'h0000_0999, 0, 1, 1);
        tv[16] = idle(1, 1, 6, 32'h1111_2222, 0, 1, 1);
        tv[17] = idle(1, 0, 0, 0, 0, 0, 2);
        tv[18] = mk(1, 0, 0, 0, 6, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 2);
        tv[19] = idle(1, 0, 0, 0, 0, 1, 2);
        tv[20] = mk(1, 1, 6, 32'h6666_0006, 0, 0, 0, 0, 0, 1, 6, 32'h6666_0006, 0, 1, 2);
        tv[21] = idle(1, 0, 0, 0, 0, 0, 2);
        tv[22] = mk(1, 0, 0, 0, 0, 4, 3, 0, 32'h4, 0, 0, 0, 0, 0, 2);
        tv[23] = idle(1, 0, 0, 0, 0, 1, 2);
        tv[24] = idle(1, 1, 4, 32'h0000_4444, 0, 1, 2);
        tv[25] = idle(1, 0, 0, 0, 0, 0, 3);
        tv[26] = mk(1, 0, 0, 0, 5, 4, 3, 32'h1, 32'h8, 0, 0, 0, 0, 0, 3);
        tv[27] = idle(1, 0, 0, 0, 0, 1, 3);
        tv[28] = idle(1, 1, 5, 32'h0000_00FF, 0, 1, 3);
        tv[29] = idle(1, 0, 0, 0, 0, 0, 4);
        tv[30] = mk(3, 0, 0, 0, 0, 4, 0, 0, 32'h20, 0, 0, 0, 0, 0, 4);
        tv[31] = idle(3, 0, 0, 0, 0, 1, 4);
        tv[32] = idle(3, 1, 4, 32'h0000_4444, 0, 1, 4);
        tv[33] = idle(1, 0, 0, 0, 0, 0, 5);
        tv[34] = mk(1, 1, 5, 32'h0000_00FF, 5, 0, 1, 32'h1, 0, 1, 5, 32'h0000_00FF, 0, 0, 5);
        tv[35] = idle(1, 0, 0, 0, 0, 0, 5);
        tv[36] = mk(1, 0, 0, 0, 7, 0, 1, 32'h3, 0, 0, 0, 0, 0, 0, 5);
        tv[37] = idle(0, 0, 0, 0, 0, 1, 5);
        tv[38] = idle(0, 0, 0, 0, 0, 0, 5);
        tv[39] = mk(1, 0, 0, 0, 5, 0, 1, 32'h1, 0, 0, 0, 0, 0, 0, 5);
        tv[40] = mk(1, 0, 0, 0, 4, 0, 1, 32'h1, 0, 0, 0, 0, 0, 1, 5);
        tv[41] = idle(1, 1, 5, 32'h0000_00FF, 0, 1, 5);
        tv[42] = idle(1, 0, 0, 0, 0, 0, 6);

        rst_n = 1'b0; corrupt = 1'b0;
        mode = 2'b00; wb_we = 1'b0; wb_add = '0; wb_val = '0;
        sm = 2'b00; swe = 1'b0; sa = '0; sv = '0;
        for (int k = 0; k < 2; k++) begin
            r_add[k] = '0; r_val[k] = '0; r_req[k] = 1'b0;
            sr_add[k] = '0; sr_val[k] = '0; sr_req[k] = 1'b0;
        end
        tick();
        tick();
        #2;
        cmp("reset.busy", 32'(busy), 32'd0);
        cmp("reset.ue", 32'(ue), 32'd0);
        cmp("reset.we", 32'(we), 32'd0);
        cmp("reset.ce", 32'(ce), 32'd0);
        cmp("reset.scr_add", 32'(scr_add), 32'd1);
        cmp("reset.scr_add_s", 32'(scr_add_s), 32'd1);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            mode     = tv[i].md;
            wb_we    = tv[i].wwe;
            wb_add   = tv[i].wa;
            wb_val   = tv[i].wv;
            r_add[0] = tv[i].a0;
            r_add[1] = tv[i].a1;
            r_req[0] = tv[i].rq[0];
            r_req[1] = tv[i].rq[1];
            r_val[0] = rf[tv[i].a0] ^ tv[i].f0;
            r_val[1] = rf[tv[i].a1] ^ tv[i].f1;
            #2;
            cmp($sformatf("v%0d.we", i), 32'(we), 32'(tv[i].ewe));
            if (tv[i].ewe) begin
                cmp($sformatf("v%0d.add", i), 32'(add), 32'(tv[i].eadd));
                cmp($sformatf("v%0d.val", i), val, tv[i].ev);
            end
            cmp($sformatf("v%0d.ue", i), 32'(ue), 32'(tv[i].eue));
            cmp($sformatf("v%0d.busy", i), 32'(busy), 32'(tv[i].ebusy));
            cmp($sformatf("v%0d.ce", i), 32'(ce), 32'(tv[i].ece));
            tick();
        end

        // reset while a repair sits in CORRECT
        mode = 2'b01; wb_we = 1'b0;
        r_add[0] = 5'd5; r_req[0] = 1'b1; r_val[0] = rf[5] ^ 32'h1;
        r_add[1] = '0; r_req[1] = 1'b0; r_val[1] = '0;
        tick();
        r_add[0] = '0; r_req[0] = 1'b0; r_val[0] = '0;
        tick();
        #2;
        cmp("rst.pre_we", 32'(we), 32'd1);
        cmp("rst.pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        cmp("rst.busy", 32'(busy), 32'd0);
        cmp("rst.we", 32'(we), 32'd0);
        cmp("rst.ce", 32'(ce), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #2;
        cmp("rst.after_busy", 32'(busy), 32'd0);
        cmp("rst.after_we", 32'(we), 32'd0);

        // background scrub on the small instance
        mode = 2'b00;
        sm = 2'b01; swe = 1'b1; sa = 3'd3; sv = 32'h1234_5678;
        tick();
        swe = 1'b0; sa = '0; sv = '0;
        corrupt = 1'b1;
        tick();
        corrupt = 1'b0;
        cmp("scr.corrupted", rf_s[3], 32'h1234_5478);
        sm = 2'b10;
        exp_seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1};
        last = scr_add_s;
        ntr = 0;
        rep = 1'b0;
        rep_val = '0;
        for (int c = 0; c < 80 && ntr < 7; c++) begin
            #2;
            if (we_s && add_s == 3'd3) begin
                rep = 1'b1;
                rep_val = val_s;
            end
            tick();
            if (scr_add_s != last) begin
                cmp($sformatf("scr.step%0d", ntr), 32'(scr_add_s), 32'(exp_seq[ntr]));
                last = scr_add_s;
                ntr++;
            end
        end
        cmp("scr.steps", 32'(ntr), 32'd7);
        cmp("scr.repair_seen", 32'(rep), 32'd1);
        cmp("scr.repair_val", rep_val, 32'h1234_5678);
        cmp("scr.rf3", rf_s[3], 32'h1234_5678);
        cmp("scr.ce", 32'(ce_s), 32'd1);
        #2;
        cmp("scr.ue", 32'(ue_s), 32'd0);
        sm = 2'b00;
        tick();
        #2;
        cmp("scr.off_busy", 32'(busy_s), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/acm_scrub.md
# acm_scrub

Parametrised single-clock automatic correction module for a SECDED-protected register file, with an integrated background scrubber. It sits beside the register file write port. It owns the checksum storage and merges writeback writes with its own repair writes. Repairs are requested on demand by any of `RP` read ports, or generated periodically by a scrub pointer that walks every register. Correctable errors are fixed in place; uncorrectable ones are flagged.

## Interface
Parameters:
- `N`, 32, number of registers (x0 hardwired, never checked or repaired)
- `RP`, 2, number of read ports able to request repair
- `SCRUB_PERIOD`, 1024, cycles between scrub launches (≥2)
- `AW`, `$clog2(N)`, address width (derived, not overridden)

Ports:
- `s_clk_i` in 1: clock
- `s_resetn_i` in 1: asynchronous, active-low reset
- `s_mode_i` in 2: 00 off, 01 on-demand, 10 on-demand + scrub, 11 forced (every read port with nonzero address requests)
- `s_wb_we_i` in 1: writeback write enable
- `s_wb_add_i` in AW: writeback address
- `s_wb_val_i` in 32: writeback data
- `s_r_add_i[RP]` in AW: read port addresses
- `s_r_val_i[RP]` in 32: read port data
- `s_r_req_i[RP]` in 1: repair request per port (discrepancy detected upstream)
- `s_scr_add_o` out AW: scrub read address to register file
- `s_scr_val_i` in 32: data read at `s_scr_add_o` (combinational)
- `s_we_o` out 1: register file write enable
- `s_add_o` out AW: register file write address
- `s_val_o` out 32: register file write data
- `s_busy_o` out 1: FSM not IDLE
- `s_ue_o` out 1: one-cycle pulse on an uncorrectable error
- `s_ce_cnt_o` out 16: count of corrected errors, saturating at 0xFFFF

## Operation
- State: FSM (`ACM_IDLE`, `ACM_CHECK`, `ACM_CORRECT`), stored address/value, scrub pointer, scrub timer, scrub-pending flag, CE counter, checksum file `N`×7.
- Port k is eligible when (`s_r_req_i[k]`, or mode 11) and `s_r_add_i[k]`≠0 and not (`s_wb_we_i` and `s_wb_add_i`==`s_r_add_i[k]`).
- IDLE, mode≠00:
  - If any port is eligible, capture the lowest eligible port's address and value, then go to CHECK.
  - Else, if scrub-pending and mode 10, capture `s_scr_add_o` and `s_scr_val_i`, clear pending, advance the pointer, then go to CHECK.
  - Requests that arrive while busy are dropped.
- Scrub timer: decrements only in mode 10. At 0 it sets scrub-pending and reloads `SCRUB_PERIOD-1`. Pending stays set until consumed or the mode leaves 10.
- Scrub pointer: wraps `N-1`→1 and skips 0.
- CHECK: syndrome = encode(stored value) XOR checksum file[stored address].
  - WB writes the stored address → IDLE (abort, data superseded).
  - Syndrome 0 → IDLE.
  - Correctable → latch decoded value, go to CORRECT.
  - Uncorrectable → pulse `s_ue_o`, go to IDLE.
- CORRECT:
  - `s_wb_we_i`=1 with the same address → IDLE, no write.
  - `s_wb_we_i`=1 with a different address → stay in CORRECT (WB owns the port).
  - Otherwise assert the write, increment the CE counter (saturating), go to IDLE.
- Write mux: the WB write has absolute priority; otherwise the ACM write happens in CORRECT.
- Checksum file: written with encode(`s_val_o`) at `s_add_o` whenever `s_we_o`=1 and mode≠00.
- `s_mode_i`→00 in any state: go to IDLE next cycle, with no ACM write or UE pulse in that cycle.

## Timing
- Reset values:
  - FSM IDLE; stored address/value 0; scrub pointer 1; timer `SCRUB_PERIOD-1`; pending 0.
  - CE counter 0; checksum file all 0 (= encode(0); the register file also resets to 0).
  - `s_busy_o`=0, `s_ue_o`=0, `s_we_o`=`s_wb_we_i` (combinational).
- Repair latency:
  - Request sampled in cycle t; CHECK in t+1; write asserted combinationally in t+2.
  - Repaired data is readable from t+3. Each WB stall adds one cycle.
- Simultaneous request and scrub launch: the request wins and the scrub stays pending.
- `s_ue_o` is asserted during the CHECK cycle itself (combinational from the registered state).

## Structure
- `p_hardisc`: reuse the `ACM_*` FSM encodings; add a typedef for the 16-bit CE counter.
- Reuse `secded_encode`, `secded_analyze`, `secded_decode` and `seu_ff_file` (checksum storage, 1 read port).
- One new sub-module, `acm_req_arb`: a fixed-priority eligibility filter and one-hot select over `RP` ports, returning valid, address and value.

## Test plan
- **Single-bit repair:** write x5=0x0000_00FF, flip bit 3 of the read value, assert `s_r_req_i[0]` with address 5.
  - Required: `s_we_o`=1, `s_add_o`=5, `s_val_o`=0x0000_00FF at t+2; `s_ce_cnt_o`=1.
- **Double-bit error:** flip bits 0 and 1 of x7 and request a repair.
  - Required: `s_ue_o` pulses one cycle at t+1; no ACM write; count unchanged.
- **WB collision in CORRECT:** WB writes x9 in cycle t+2.
  - Different target (repair of x6 pending): ACM write delayed to t+3.
  - WB writes x6 instead: FSM goes to IDLE with no ACM write.
- **Port priority and x0 exclusion:** port 0 address 0 and port 1 address 4, both requesting.
  - Required: address 4 captured. With both nonzero, port 0 wins.
- **Scrub:** `SCRUB_PERIOD`=4, `N`=8, mode 10.
  - Required: `s_scr_add_o` steps 1,2,…,7,1. A corrupted x3 is repaired without any read request.
- **Reset and mode off:** assert `s_resetn_i` low in CORRECT, or move mode to 00 in CHECK.
  - Required: reset clears all state immediately; mode 00 gives IDLE next cycle; no write in either case.
